// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM state encoding and width helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_PARITY     = 3'd3;
    localparam logic [2:0] S_STOP       = 3'd4;
    localparam logic [2:0] S_BREAK_WAIT = 3'd5;

    // Bits needed to count 0..value-1 (at least one bit).
    function automatic int unsigned clogb2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((64'd1 << width) < 64'(value)) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/uart_receiver_cfg_if.sv
// Receiver output bundle: word, error tags and valid/ready handshake towards the consumer.
interface uart_receiver_cfg_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_o;
    logic                 data_valid_o;
    logic                 frame_error_o;
    logic                 parity_error_o;
    logic                 overrun_o;
    logic                 buffer_ready_i;

    modport master (
        output data_o, data_valid_o, frame_error_o, parity_error_o, overrun_o,
        input  buffer_ready_i
    );

    modport slave (
        input  data_o, data_valid_o, frame_error_o, parity_error_o, overrun_o,
        output buffer_ready_i
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter 0..FULL-1 with synchronous clear; decodes the half-bit and full-bit points.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned FULL = 125,
    parameter int unsigned HALF = FULL / 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic half_tick_c,
    output logic full_tick_c
);

    localparam int unsigned CNT_W = clogb2(FULL);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign full_tick_c = (cnt_q == CNT_W'(FULL - 1));
    assign half_tick_c = (cnt_q == CNT_W'(HALF - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || full_tick_c) cnt_d = '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_receiver_cfg.sv
// Configurable UART receiver with glitch-rejecting start detection and held valid/ready output.
// Define UART_RX_MAJORITY_EN to take a 2-of-3 vote around every sample point.
module uart_receiver_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 115200000,
    parameter int unsigned BAUDRATE    = 921600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    uart_receiver_cfg_if.master rx_if
);

    localparam int unsigned FULL      = CLK_FREQ_HZ / BAUDRATE;
    localparam int unsigned HALF      = FULL / 2;
    localparam int unsigned BIT_CNT_W = clogb2(DATA_BITS);

    if (FULL < 8) begin : g_err_full
        $error("uart_receiver_cfg: CLK_FREQ_HZ/BAUDRATE must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_bits
        $error("uart_receiver_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > PARITY_EVEN) begin : g_err_par
        $error("uart_receiver_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
        $error("uart_receiver_cfg: STOP_BITS must be 1 or 2");
    end

    // RXD synchronizer plus history for edge detection (and voting when enabled)
    logic rxd_meta_q, rxd_meta_d;
    logic rxd_sync_q, rxd_sync_d;
    logic rxd_prev_q, rxd_prev_d;
    logic sample_c;

`ifdef UART_RX_MAJORITY_EN
    logic rxd_prev2_q, rxd_prev2_d;

    always_comb rxd_prev2_d = rxd_prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rxd_prev2_q <= 1'b1;
        else       rxd_prev2_q <= rxd_prev2_d;
    end

    assign sample_c = (rxd_sync_q & rxd_prev_q) | (rxd_sync_q & rxd_prev2_q) |
                      (rxd_prev_q & rxd_prev2_q);
`else
    assign sample_c = rxd_sync_q;
`endif

    always_comb begin
        rxd_meta_d = rxd_i;
        rxd_sync_d = rxd_meta_q;
        rxd_prev_d = rxd_sync_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd_meta_d;
            rxd_sync_q <= rxd_sync_d;
            rxd_prev_q <= rxd_prev_d;
        end
    end

    logic [2:0]           state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 done_c;
    logic                 half_tick_c, full_tick_c;

    uart_bit_timer #(
        .FULL (FULL),
        .HALF (HALF)
    ) u_bit_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (state_d != state_q),
        .half_tick_c (half_tick_c),
        .full_tick_c (full_tick_c)
    );

    // Frame FSM; done_c marks the last stop sample
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        ferr_d     = ferr_q;
        perr_d     = perr_q;
        done_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rxd_prev_q && !rxd_sync_q) state_d = S_START;
            end
            S_START: begin
                if (half_tick_c) begin
                    if (sample_c) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_cnt_d  = '0;
                        stop_cnt_d = 1'b0;
                        ferr_d     = 1'b0;
                        perr_d     = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (full_tick_c) begin
                    shreg_d = {sample_c, shreg_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (full_tick_c) begin
                    perr_d  = (((^shreg_q) ^ sample_c) != (PARITY == PARITY_ODD));
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (full_tick_c) begin
                    if (!sample_c) ferr_d = 1'b1;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done_c  = 1'b1;
                        state_d = sample_c ? S_IDLE : S_BREAK_WAIT;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            S_BREAK_WAIT: begin
                if (rxd_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
        end
    end

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_out_q, ferr_out_d;
    logic                 perr_out_q, perr_out_d;
    logic                 ovr_q, ovr_d;
    logic                 xfer_c;

    assign xfer_c = valid_q && rx_if.buffer_ready_i;

    // Output holding register: a new word only replaces one that is empty or leaving
    always_comb begin
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_out_d = ferr_out_q;
        perr_out_d = perr_out_q;
        ovr_d      = 1'b0;
        if (xfer_c) valid_d = 1'b0;
        if (done_c) begin
            if (!valid_q || xfer_c) begin
                data_d     = shreg_q;
                ferr_out_d = ferr_d;
                perr_out_d = perr_d;
                valid_d    = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_out_q <= 1'b0;
            perr_out_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_out_q <= ferr_out_d;
            perr_out_q <= perr_out_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rx_if.data_o         = data_q;
    assign rx_if.data_valid_o   = valid_q;
    assign rx_if.frame_error_o  = ferr_out_q;
    assign rx_if.parity_error_o = perr_out_q;
    assign rx_if.overrun_o      = ovr_q;

endmodule

// File: tb/tb_uart_receiver_cfg.sv
// Bench for uart_receiver_cfg: an 8N1 instance and an 8E2 instance driven with serial frames.
module tb_uart_receiver_cfg;

    localparam int FULL = 125;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } rx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxd_a = 1'b1;
    logic rxd_b = 1'b1;

    always #5 clk = ~clk;

    uart_receiver_cfg_if #(.DATA_BITS(8)) ifa ();
    uart_receiver_cfg_if #(.DATA_BITS(8)) ifb ();

    uart_receiver_cfg dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .rxd_i (rxd_a),
        .rx_if (ifa)
    );

    uart_receiver_cfg #(
        .PARITY    (2),
        .STOP_BITS (2)
    ) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .rxd_i (rxd_b),
        .rx_if (ifb)
    );

    rx_t got_a[$];
    rx_t got_b[$];
    int  ovr_a, ovr_b, vcyc_a;
    int  n_vec, n_err;

    // Record every handshake transfer and overrun pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (ifa.data_valid_o) begin
                vcyc_a++;
                if (ifa.buffer_ready_i)
                    got_a.push_back(rx_t'({ifa.data_o, ifa.frame_error_o, ifa.parity_error_o}));
            end
            if (ifb.data_valid_o && ifb.buffer_ready_i)
                got_b.push_back(rx_t'({ifb.data_o, ifb.frame_error_o, ifb.parity_error_o}));
            if (ifa.overrun_o) ovr_a++;
            if (ifb.overrun_o) ovr_b++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input int inst, input logic v, input int cycles);
        if (inst == 0) rxd_a = v;
        else           rxd_b = v;
        repeat (cycles) @(negedge clk);
    endtask

    // Serial frame: start, 8 data LSB first, optional parity, nstop stop bits (stops[0] first)
    task automatic send_frame(input int inst, input logic [7:0] d, input logic use_par,
                              input logic par_bit, input int nstop, input logic [1:0] stops,
                              input int glitch_bit);
        drive(inst, 1'b0, FULL);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive(inst, d[i], FULL / 2);
                drive(inst, ~d[i], 1);
                drive(inst, d[i], FULL - FULL / 2 - 1);
            end else begin
                drive(inst, d[i], FULL);
            end
        end
        if (use_par) drive(inst, par_bit, FULL);
        for (int s = 0; s < nstop; s++) drive(inst, stops[s], FULL);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({ifa.data_valid_o, ifa.data_o, ifa.frame_error_o, ifa.parity_error_o, ifa.overrun_o} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_a outputs got v=%b d=%h fe=%b pe=%b ov=%b expected all 0",
                     ifa.data_valid_o, ifa.data_o, ifa.frame_error_o, ifa.parity_error_o, ifa.overrun_o);
        end
        n_vec++;
        if ({ifb.data_valid_o, ifb.data_o, ifb.frame_error_o, ifb.parity_error_o, ifb.overrun_o} !== 12'h0) begin
            n_err++;
            $display("FAIL reset_b outputs got v=%b d=%h fe=%b pe=%b ov=%b expected all 0",
                     ifb.data_valid_o, ifb.data_o, ifb.frame_error_o, ifb.parity_error_o, ifb.overrun_o);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_8n1();
        rx_t exp_w;
        exp_w = rx_t'({8'hA5, 1'b0, 1'b0});
        got_a.delete();
        vcyc_a = 0;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== 1) begin
            n_err++;
            $display("FAIL 8n1_count got %0d words expected 1", got_a.size());
        end else begin
            n_vec++;
            if (got_a[0] !== exp_w) begin
                n_err++;
                $display("FAIL 8n1_word got %h expected %h", got_a[0], exp_w);
            end
        end
        n_vec++;
        if (vcyc_a !== 1) begin
            n_err++;
            $display("FAIL 8n1_valid_cycles got %0d expected 1", vcyc_a);
        end
        n_vec++;
        if (ifa.data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL 8n1_valid_drop got %b expected 0", ifa.data_valid_o);
        end
    endtask

    task automatic test_parity();
        logic [7:0] d;
        rx_t exp_w;
        d = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            got_b.delete();
            send_frame(1, d, 1'b1, (k == 0) ? ~(^d) : (^d), 2, 2'b11, -1);
            drive(1, 1'b1, 20);
            exp_w = rx_t'({d, 1'b0, (k == 0)});
            n_vec++;
            if (got_b.size() !== 1 || got_b[0] !== exp_w) begin
                n_err++;
                $display("FAIL parity_%0d got %0d words first=%h expected 1 word %h",
                         k, got_b.size(), (got_b.size() > 0) ? got_b[0] : rx_t'(0), exp_w);
            end
        end
    endtask

    task automatic test_glitch();
        got_a.delete();
        drive(0, 1'b0, 40);
        drive(0, 1'b1, 200);
        n_vec++;
        if (got_a.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_no_word got %0d words expected 0", got_a.size());
        end
        send_frame(0, 8'h55, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h55, 1'b0, 1'b0})) begin
            n_err++;
            $display("FAIL glitch_next_frame got %0d words first=%h expected 1 word 154",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0));
        end
    endtask

    task automatic test_break();
        got_a.delete();
        send_frame(0, 8'h81, 1'b0, 1'b0, 1, 2'b00, -1);
        drive(0, 1'b0, 500);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h81, 1'b1, 1'b0})) begin
            n_err++;
            $display("FAIL break_word got %0d words first=%h expected 1 word 206",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0));
        end
        drive(0, 1'b1, 20);
        got_a.delete();
        send_frame(0, 8'h12, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h12, 1'b0, 1'b0})) begin
            n_err++;
            $display("FAIL break_recover got %0d words first=%h expected 1 word 048",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0));
        end
    endtask

    task automatic test_overrun();
        got_a.delete();
        ovr_a = 0;
        @(posedge clk); #1 ifa.buffer_ready_i = 1'b0;
        @(negedge clk);
        send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if ({ifa.data_valid_o, ifa.data_o} !== 9'h111) begin
            n_err++;
            $display("FAIL overrun_hold got v=%b d=%h expected v=1 d=11", ifa.data_valid_o, ifa.data_o);
        end
        n_vec++;
        if (ovr_a !== 1) begin
            n_err++;
            $display("FAIL overrun_pulses got %0d expected 1", ovr_a);
        end
        n_vec++;
        if (got_a.size() !== 0) begin
            n_err++;
            $display("FAIL overrun_no_transfer got %0d expected 0", got_a.size());
        end
        @(posedge clk); #1 ifa.buffer_ready_i = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h11, 1'b0, 1'b0}) || ifa.data_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_release got %0d words first=%h valid=%b expected 1 word 044 valid=0",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0), ifa.data_valid_o);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d77;
        d77 = 8'h77;
        @(posedge clk); #1 ifa.buffer_ready_i = 1'b0;
        @(negedge clk);
        send_frame(0, 8'hAA, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if ({ifa.data_valid_o, ifa.data_o} !== 9'h1AA) begin
            n_err++;
            $display("FAIL midreset_pre got v=%b d=%h expected v=1 d=aa", ifa.data_valid_o, ifa.data_o);
        end
        drive(0, 1'b0, FULL);
        for (int i = 0; i < 3; i++) drive(0, d77[i], FULL);
        drive(0, d77[3], FULL / 2);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({ifa.data_valid_o, ifa.data_o, ifa.frame_error_o, ifa.parity_error_o, ifa.overrun_o} !== 12'h0) begin
            n_err++;
            $display("FAIL midreset_outputs got v=%b d=%h fe=%b pe=%b ov=%b expected all 0",
                     ifa.data_valid_o, ifa.data_o, ifa.frame_error_o, ifa.parity_error_o, ifa.overrun_o);
        end
        @(negedge clk);
        rxd_a = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1 ifa.buffer_ready_i = 1'b1;
        @(negedge clk);
        got_a.delete();
        drive(0, 1'b1, 100);
        send_frame(0, 8'h99, 1'b0, 1'b0, 1, 2'b11, -1);
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h99, 1'b0, 1'b0})) begin
            n_err++;
            $display("FAIL midreset_next got %0d words first=%h expected 1 word 264",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0));
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority_glitch();
        got_a.delete();
        send_frame(0, 8'h99, 1'b0, 1'b0, 1, 2'b11, 3);
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== 1 || got_a[0] !== rx_t'({8'h99, 1'b0, 1'b0})) begin
            n_err++;
            $display("FAIL majority_glitch got %0d words first=%h expected 1 word 264",
                     got_a.size(), (got_a.size() > 0) ? got_a[0] : rx_t'(0));
        end
    endtask
`endif

    // Random 8N1 frames with occasional bad stop bits and zero-gap back-to-back runs
    task automatic test_back_to_back();
        rx_t exp_q[$];
        logic [7:0] d;
        logic ok;
        int gap;
        got_a.delete();
        for (int f = 0; f < 12; f++) begin
            d  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(0, d, 1'b0, 1'b0, 1, {1'b1, ok}, -1);
            exp_q.push_back(rx_t'({d, ~ok, 1'b0}));
            if (!ok)        gap = $urandom_range(10, 150);
            else if (f < 3) gap = 0;
            else            gap = $urandom_range(0, 150);
            if (gap > 0) drive(0, 1'b1, gap);
        end
        drive(0, 1'b1, 20);
        n_vec++;
        if (got_a.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL b2b_count got %0d expected %0d", got_a.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
            n_vec++;
            if (got_a[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_word[%0d] got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", i,
                         got_a[i].data, got_a[i].ferr, got_a[i].perr,
                         exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    // Random 8E2 frames with random parity corruption and stop-bit errors
    task automatic test_random_parity();
        rx_t exp_q[$];
        logic [7:0] d;
        logic flip, s0, s1;
        int gap;
        got_b.delete();
        for (int f = 0; f < 8; f++) begin
            d    = 8'($urandom);
            flip = 1'($urandom_range(0, 1));
            s0   = ($urandom_range(0, 4) != 0);
            s1   = ($urandom_range(0, 4) != 0);
            send_frame(1, d, 1'b1, (^d) ^ flip, 2, {s1, s0}, -1);
            exp_q.push_back(rx_t'({d, ~(s0 & s1), flip}));
            gap = s1 ? $urandom_range(0, 150) : $urandom_range(10, 150);
            if (gap > 0) drive(1, 1'b1, gap);
        end
        drive(1, 1'b1, 20);
        n_vec++;
        if (got_b.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rand_par_count got %0d expected %0d", got_b.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++) begin
            n_vec++;
            if (got_b[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rand_par_word[%0d] got d=%h fe=%b pe=%b expected d=%h fe=%b pe=%b", i,
                         got_b[i].data, got_b[i].ferr, got_b[i].perr,
                         exp_q[i].data, exp_q[i].ferr, exp_q[i].perr);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ovr_a = 0;
        ovr_b = 0;
        vcyc_a = 0;
        ifa.buffer_ready_i = 1'b1;
        ifb.buffer_ready_i = 1'b1;
        test_reset();
        test_8n1();
        test_parity();
        test_glitch();
        test_break();
        test_overrun();
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        test_majority_glitch();
`endif
        test_back_to_back();
        test_random_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_receiver_cfg.md
Name: uart_receiver_cfg

Overview:
Parametrised successor UART receiver: configurable data width, parity mode and stop-bit count, with start-bit glitch rejection and framing, parity and overrun reporting. Sits between the board RXD pin and the input buffer or command parser. Output uses a valid/ready handshake, and the received word is held until it is accepted.

Parameters:
CLK_FREQ_HZ, 115200000, clock frequency in Hz.
BAUDRATE, 921600, line rate in bit/s; FULL = CLK_FREQ_HZ/BAUDRATE, HALF = FULL/2; elaboration error if FULL < 8.
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
rxd_i  in  1  asynchronous UART RXD line, idle high
buffer_ready_i  in  1  consumer ready; a transfer occurs when data_valid_o and buffer_ready_i are both 1
data_o  out  DATA_BITS  received word
data_valid_o  out  1  data_o valid; held until transfer
frame_error_o  out  1  tag on the word: at least one stop bit was sampled 0
parity_error_o  out  1  tag on the word: parity mismatch (always 0 when PARITY=0)
overrun_o  out  1  one-cycle pulse: a completed frame was dropped

Behaviour:
- Reset: the asynchronous assert forces all outputs to 0. The 2-flop rxd synchronizer resets to 1 (line idle) and the FSM resets to IDLE. Reset mid-frame discards the frame in progress; no partial word is delivered.
- Bit-timing counter: 0..FULL-1, cleared on every state change.
- Falling edge on synchronized rxd (previous 1, current 0) in IDLE → START.
- FSM states and transitions:
  - IDLE → START on the falling edge above.
  - START: sample at count HALF-1. Sample 1 → glitch, back to IDLE with no flags. Sample 0 → DATA.
  - DATA: sample at FULL-1 and shift in LSB first. After DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY: sample at FULL-1. Odd mode requires the XOR of data and parity bit = 1; even mode requires it = 0.
  - STOP: STOP_BITS samples at FULL-1 each. Any sample 0 sets the frame error.
  - After the last stop sample → IDLE if the line is 1. If the line is 0 (break), → BREAK_WAIT, which stays until rxd = 1 for one cycle and then goes to IDLE.
- Delivery: on the cycle after the last stop sample, the word and error tags load into the output registers together and data_valid_o = 1. Latency from the mid-point of the last stop bit is 1 clock plus 2 synchronizer clocks.
- Output register holds data_o, tags and valid stable until transfer. On a transfer cycle with no new frame, valid drops to 0 on the next edge.
- New frame completes while valid=1 and ready=0: new word dropped, old word kept, overrun_o pulses for 1 cycle.
- New frame completes in the same cycle as a transfer: new word loaded, valid stays 1, no overrun.
- Back-to-back frames with zero idle between the stop bit and the next start bit must be received.

Optional Feature:
- UART_RX_MAJORITY_EN defined: each sample point (start, data, parity, stop) takes the 2-of-3 majority of synchronized rxd at counts N-2, N-1 and N, where N is the nominal sample count. Bit timing is unchanged and a single-cycle glitch is rejected.
- Undefined: a single sample at count N.

Decomposition:
- Package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants;
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - the clogb2 function.
- One natural sub-module: uart_bit_timer (counter with clear, half_tick at HALF-1, full_tick at FULL-1), reusable by a future transmitter.

Test Plan:
- Defaults (FULL=125), 8N1, frame 0xA5, buffer_ready_i=1 → data_o=0xA5, one valid cycle, both error tags 0.
- PARITY=2, frame 0x3C with parity bit 1 (wrong) → data_o=0x3C, parity_error_o=1. Same frame with parity bit 0 → parity_error_o=0.
- 40-cycle low pulse on rxd → no valid; FSM back in IDLE; a following 0x55 frame → 0x55.
- Stop bit driven 0 for frame 0x81, line then held low 500 cycles → data_o=0x81, frame_error_o=1; no further frame until rxd returns high; next frame 0x12 → 0x12.
- buffer_ready_i=0, frames 0x11 then 0x22 → data_o stays 0x11 and valid stays 1; overrun_o pulses once at end of 0x22; ready=1 → 0x11 transferred, valid drops.
- Reset asserted mid-data-bit of frame 0x77 → outputs immediately 0; next full frame 0x99 → 0x99. With UART_RX_MAJORITY_EN, a 1-cycle glitch at the mid-point of data bit 3 does not corrupt 0x99.
